// File: rtl/rv_boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: default widths, host command
// encodings, sequencer state encoding and header field positions.
package rv_boot_sequencer_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 16;

    // Command field of a header word: header[HDR_CMD_HI:HDR_CMD_LO].
    // The word count sits in header[CNT_W-1:0].
    localparam int HDR_CMD_HI = 31;
    localparam int HDR_CMD_LO = 30;

    typedef enum logic [1:0] {
        CMD_LOAD_IMEM = 2'd0,
        CMD_LOAD_DMEM = 2'd1,
        CMD_RUN       = 2'd2,
        CMD_NOP       = 2'd3
    } cmdT;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        PCW  = 3'd3,
        RUN  = 3'd4
    } seqStateT;

    // Word accesses need a 4-byte aligned byte address.
    function automatic logic isWordAligned(input logic [1:0] addrLsbs);
        return addrLsbs == 2'b00;
    endfunction

endpackage

// File: rtl/rv_boot_sequencer_timer.sv
// rv_run_timer: run budget and cycle accounting for one core run.
//   clk, rst_n     clock, async active-low reset
//   start          one-cycle pulse on the start-PC beat
//   startCount     cycle budget for the run (0 = finish immediately)
//   abort          end the run after the current cycle
//   runActive      core fetch enable, high for the budgeted cycles
//   runLast        high in the final active cycle (budget exhausted or abort)
//   donePulse      one-cycle pulse in the first cycle after the run
//   cyclesRun      number of cycles runActive was high in the last run
module rv_run_timer
    import rv_boot_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] startCount,
    input  logic             abort,
    output logic             runActive,
    output logic             runLast,
    output logic             donePulse,
    output logic [CNT_W-1:0] cyclesRun
);

    logic [CNT_W-1:0] budget;

    // Terminal-count compare: the cycle with one budget unit left is the last.
    // An abort in the last budgeted cycle lands here too, so only one done.
    assign runLast = runActive & ((budget == CNT_W'(1)) | abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runActive <= 1'b0;
            budget    <= '0;
            cyclesRun <= '0;
            donePulse <= 1'b0;
        end else begin
            donePulse <= 1'b0;
            if (start) begin
                cyclesRun <= '0;
                budget    <= startCount;
                runActive <= (startCount != '0);
                donePulse <= (startCount == '0);
            end else if (runActive) begin
                cyclesRun <= cyclesRun + CNT_W'(1);
                budget    <= budget - CNT_W'(1);
                if (runLast) begin
                    runActive <= 1'b0;
                    donePulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rv_boot_sequencer.sv
// rv_boot_sequencer: host-facing loader and run controller for the RISC-V
// overlay core. Consumes a header/address/data word stream to fill imem or
// dmem, or a header/start-PC pair to run the core for a bounded budget.
//   clk, rst_n              clock, async active-low reset
//   host_valid/ready/data   host word stream (valid/ready handshake)
//   abort_i                 terminate an active run early
//   imem_wr_*, dmem_wr_*    memory write ports (one-cycle strobes)
//   core_pc_valid           core fetch enable
//   core_pc_start_minus4    start PC minus 4, held until the next run
//   busy_o, done_o          not idle / one-cycle end-of-run pulse
//   cycles_run_o            cycles the core ran in the last run
//   err_o                   sticky misaligned-address error
//
// state | meaning
// IDLE  | waiting for a header word
// ADDR  | waiting for the load base address
// DATA  | consuming load data words, one write per beat
// PCW   | waiting for the start PC
// RUN   | core fetch enabled, host stalled
module rv_boot_sequencer
    import rv_boot_sequencer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [XLEN-1:0]  host_data,
    input  logic             abort_i,
    output logic             imem_wr_valid,
    output logic [XLEN-1:0]  imem_wr_addr,
    output logic [XLEN-1:0]  imem_wr_data,
    output logic             dmem_wr_valid,
    output logic [XLEN-1:0]  dmem_wr_addr,
    output logic [XLEN-1:0]  dmem_wr_data,
    output logic             core_pc_valid,
    output logic [XLEN-1:0]  core_pc_start_minus4,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycles_run_o,
    output logic             err_o
);

    seqStateT         state;
    seqStateT         stateNext;
    logic             beat;
    cmdT              hdrCmd;
    logic [CNT_W-1:0] hdrCount;
    logic [CNT_W-1:0] wordsLeft;
    logic [XLEN-1:0]  writeAddr;
    logic             loadImem;
    logic             suppressWr;
    logic             timerStart;
    logic             timerActive;
    logic             timerLast;
    logic             timerDone;
    logic [CNT_W-1:0] timerCycles;

    assign beat     = host_valid & host_ready;
    assign hdrCmd   = cmdT'(host_data[XLEN-1 -: 2]);
    assign hdrCount = host_data[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        host_ready = (state != RUN);
        timerStart = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    case (hdrCmd)
                        CMD_LOAD_IMEM, CMD_LOAD_DMEM: stateNext = ADDR;
                        CMD_RUN:                      stateNext = PCW;
                        default:                      stateNext = IDLE;
                    endcase
                end
            end
            ADDR: begin
                if (beat) begin
                    stateNext = (wordsLeft == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (beat && (wordsLeft == CNT_W'(1))) begin
                    stateNext = IDLE;
                end
            end
            PCW: begin
                if (beat) begin
                    timerStart = 1'b1;
                    stateNext  = (wordsLeft == '0) ? IDLE : RUN;
                end
            end
            RUN: begin
                if (timerLast) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wordsLeft            <= '0;
            writeAddr            <= '0;
            loadImem             <= 1'b0;
            suppressWr           <= 1'b0;
            err_o                <= 1'b0;
            imem_wr_valid        <= 1'b0;
            imem_wr_addr         <= '0;
            imem_wr_data         <= '0;
            dmem_wr_valid        <= 1'b0;
            dmem_wr_addr         <= '0;
            dmem_wr_data         <= '0;
            core_pc_start_minus4 <= '0;
        end else begin
            imem_wr_valid <= 1'b0;
            dmem_wr_valid <= 1'b0;
            if (beat) begin
                case (state)
                    IDLE: begin
                        wordsLeft <= hdrCount;
                        loadImem  <= (hdrCmd == CMD_LOAD_IMEM);
                    end
                    ADDR: begin
                        writeAddr  <= host_data;
                        suppressWr <= !isWordAligned(host_data[1:0]);
                        if (!isWordAligned(host_data[1:0])) begin
                            err_o <= 1'b1;
                        end
                    end
                    DATA: begin
                        // A misaligned load still drains its data words so the
                        // host stream stays in step with the header count.
                        if (!suppressWr) begin
                            if (loadImem) begin
                                imem_wr_valid <= 1'b1;
                                imem_wr_addr  <= writeAddr;
                                imem_wr_data  <= host_data;
                            end else begin
                                dmem_wr_valid <= 1'b1;
                                dmem_wr_addr  <= writeAddr;
                                dmem_wr_data  <= host_data;
                            end
                        end
                        writeAddr <= writeAddr + XLEN'(4);
                        wordsLeft <= wordsLeft - CNT_W'(1);
                    end
                    PCW: begin
                        core_pc_start_minus4 <= host_data - XLEN'(4);
                    end
                    default: ;
                endcase
            end
        end
    end

    rv_run_timer #(
        .CNT_W(CNT_W)
    ) u_run_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (timerStart),
        .startCount(wordsLeft),
        .abort     (abort_i),
        .runActive (timerActive),
        .runLast   (timerLast),
        .donePulse (timerDone),
        .cyclesRun (timerCycles)
    );

    assign core_pc_valid = timerActive;
    assign done_o        = timerDone;
    assign cycles_run_o  = timerCycles;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_rv_boot_sequencer.sv
module tb_rv_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_data;
    logic        abort_i;
    logic        imem_wr_valid;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        dmem_wr_valid;
    logic [31:0] dmem_wr_addr;
    logic [31:0] dmem_wr_data;
    logic        core_pc_valid;
    logic [31:0] core_pc_start_minus4;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cycles_run_o;
    logic        err_o;

    always #5 clk = ~clk;

    rv_boot_sequencer #(.XLEN(32), .CNT_W(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .host_valid          (host_valid),
        .host_ready          (host_ready),
        .host_data           (host_data),
        .abort_i             (abort_i),
        .imem_wr_valid       (imem_wr_valid),
        .imem_wr_addr        (imem_wr_addr),
        .imem_wr_data        (imem_wr_data),
        .dmem_wr_valid       (dmem_wr_valid),
        .dmem_wr_addr        (dmem_wr_addr),
        .dmem_wr_data        (dmem_wr_data),
        .core_pc_valid       (core_pc_valid),
        .core_pc_start_minus4(core_pc_start_minus4),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .cycles_run_o        (cycles_run_o),
        .err_o               (err_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wrT;

    wrT expImem[$];
    wrT expDmem[$];
    wrT obsImem[$];
    wrT obsDmem[$];
    int pcValidCycles = 0;
    int donePulses    = 0;
    int readyInRun    = 0;
    int checks = 0;
    int errors = 0;

    // Observation side of the scoreboard: records every write and run event.
    always @(negedge clk) begin
        if (imem_wr_valid) obsImem.push_back('{imem_wr_addr, imem_wr_data});
        if (dmem_wr_valid) obsDmem.push_back('{dmem_wr_addr, dmem_wr_data});
        if (core_pc_valid) pcValidCycles++;
        if (done_o) donePulses++;
        if (core_pc_valid && host_ready) readyInRun++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called right after a negedge; returns right after the negedge that
    // follows the accepting posedge.
    task automatic sendWord(input logic [31:0] w, input int maxGap);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        if (maxGap > 0) repeat ($urandom_range(maxGap, 0)) @(negedge clk);
        host_valid = 1'b1;
        host_data  = w;
        for (int t = 0; t < 200 && !accepted; t++) begin
            rdy = host_ready;
            @(posedge clk);
            @(negedge clk);
            accepted = rdy;
        end
        host_valid = 1'b0;
        host_data  = $urandom;
        if (!accepted) check("host_accept", {31'd0, accepted}, 32'd1);
    endtask

    function automatic logic [31:0] header(input logic [1:0] cmd, input logic [15:0] cnt);
        return {cmd, 14'h2AA5, cnt};
    endfunction

    task automatic compareQueues(input string tag);
        check({tag, "_imem_count"}, obsImem.size(), expImem.size());
        check({tag, "_dmem_count"}, obsDmem.size(), expDmem.size());
        while (obsImem.size() > 0 && expImem.size() > 0) begin
            wrT o, e;
            o = obsImem.pop_front();
            e = expImem.pop_front();
            check({tag, "_imem_addr"}, o.addr, e.addr);
            check({tag, "_imem_data"}, o.data, e.data);
        end
        while (obsDmem.size() > 0 && expDmem.size() > 0) begin
            wrT o, e;
            o = obsDmem.pop_front();
            e = expDmem.pop_front();
            check({tag, "_dmem_addr"}, o.addr, e.addr);
            check({tag, "_dmem_data"}, o.data, e.data);
        end
        obsImem.delete(); expImem.delete(); obsDmem.delete(); expDmem.delete();
    endtask

    task automatic loadWords(input logic [1:0] cmd, input logic [31:0] base,
                             input int n, input int maxGap, input logic expectWrites);
        logic [31:0] d;
        sendWord(header(cmd, 16'(n)), maxGap);
        sendWord(base, maxGap);
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            if (expectWrites) begin
                if (cmd == 2'd0) expImem.push_back('{base + 32'(4 * i), d});
                else             expDmem.push_back('{base + 32'(4 * i), d});
            end
            sendWord(d, maxGap);
        end
    endtask

    initial begin
        int pcBase, doneBase, readyBase, waited;
        logic seenDone;

        rst_n = 1'b0; host_valid = 1'b0; host_data = '0; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pcvalid", core_pc_valid, 0);
        check("rst_pcm4", core_pc_start_minus4, 0);
        check("rst_cycles", cycles_run_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // imem load, fixed data
        sendWord(header(2'd0, 16'd3), 0);
        sendWord(32'h0000_0100, 0);
        expImem.push_back('{32'h100, 32'hAAAA_0001}); sendWord(32'hAAAA_0001, 0);
        expImem.push_back('{32'h104, 32'hBBBB_0002}); sendWord(32'hBBBB_0002, 0);
        expImem.push_back('{32'h108, 32'hCCCC_0003}); sendWord(32'hCCCC_0003, 0);
        check("imem_busy_after", busy_o, 0);
        repeat (3) @(negedge clk);
        compareQueues("imem3");

        // misaligned dmem load: error, no writes, words consumed
        loadWords(2'd1, 32'h0000_0202, 2, 0, 1'b0);
        check("misal_busy", busy_o, 0);
        check("misal_err", err_o, 1);
        repeat (3) @(negedge clk);
        compareQueues("misal");

        // dmem load wrapping the address space
        loadWords(2'd1, 32'hFFFF_FFFC, 2, 0, 1'b1);
        repeat (3) @(negedge clk);
        compareQueues("wrap");

        // run count=10 from PC 0
        pcBase = pcValidCycles; doneBase = donePulses; readyBase = readyInRun;
        sendWord(header(2'd2, 16'd10), 0);
        sendWord(32'h0, 0);
        check("run10_first_pcvalid", core_pc_valid, 1);
        check("run10_pcm4", core_pc_start_minus4, 32'hFFFF_FFFC);
        check("run10_ready_low", host_ready, 0);
        seenDone = 1'b0; waited = 0;
        for (int i = 0; i < 60 && !seenDone; i++) begin
            @(negedge clk);
            waited++;
            seenDone = done_o;
        end
        check("run10_done_seen", seenDone, 1);
        check("run10_done_latency", waited, 10);
        check("run10_cycles", cycles_run_o, 10);
        check("run10_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        check("run10_pc_cycles", pcValidCycles - pcBase, 10);
        check("run10_done_count", donePulses - doneBase, 1);
        check("run10_ready_in_run", readyInRun - readyBase, 0);

        // abort at cycle 7 of a 100-cycle run
        pcBase = pcValidCycles; doneBase = donePulses;
        sendWord(header(2'd2, 16'd100), 0);
        sendWord(32'h8000_0000, 0);
        repeat (6) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_pcvalid", core_pc_valid, 0);
        check("abort_done", done_o, 1);
        check("abort_cycles", cycles_run_o, 7);
        check("abort_pcm4", core_pc_start_minus4, 32'h7FFF_FFFC);
        repeat (3) @(negedge clk);
        check("abort_pc_cycles", pcValidCycles - pcBase, 7);
        check("abort_done_count", donePulses - doneBase, 1);

        // abort coinciding with budget expiry
        doneBase = donePulses;
        sendWord(header(2'd2, 16'd3), 0);
        sendWord(32'h0000_0040, 0);
        repeat (2) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abexp_pcvalid", core_pc_valid, 0);
        check("abexp_cycles", cycles_run_o, 3);
        repeat (3) @(negedge clk);
        check("abexp_done_count", donePulses - doneBase, 1);

        // abort outside RUN is ignored
        doneBase = donePulses;
        abort_i = 1'b1;
        repeat (3) @(negedge clk);
        abort_i = 1'b0;
        check("idle_abort_done", donePulses - doneBase, 0);
        check("idle_abort_busy", busy_o, 0);

        // run count=0
        pcBase = pcValidCycles;
        sendWord(header(2'd2, 16'd0), 0);
        sendWord(32'h0000_0010, 0);
        check("run0_done", done_o, 1);
        check("run0_cycles", cycles_run_o, 0);
        check("run0_pcm4", core_pc_start_minus4, 32'h0000_000C);
        check("run0_busy", busy_o, 0);
        @(negedge clk);
        check("run0_done_drop", done_o, 0);
        check("run0_pc_cycles", pcValidCycles - pcBase, 0);

        // imem load with random host_valid gaps
        loadWords(2'd0, 32'h0000_1000, 6, 3, 1'b1);
        repeat (3) @(negedge clk);
        compareQueues("gaps");
        check("err_sticky", err_o, 1);

        // reset during DATA after 2 of 4 words
        sendWord(header(2'd0, 16'd4), 0);
        sendWord(32'h0000_2000, 0);
        expImem.push_back('{32'h2000, 32'h1111_0000}); sendWord(32'h1111_0000, 0);
        expImem.push_back('{32'h2004, 32'h2222_0000}); sendWord(32'h2222_0000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstdata_busy", busy_o, 0);
        check("rstdata_imem_valid", imem_wr_valid, 0);
        check("rstdata_imem_addr", imem_wr_addr, 0);
        check("rstdata_err", err_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sendWord(32'h3333_0000, 0);
        sendWord(header(2'd3, 16'd5), 0);
        check("rstdata_nop_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        compareQueues("rstdata");

        // reset during RUN
        sendWord(header(2'd2, 16'd50), 0);
        sendWord(32'h0000_0400, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstrun_pcvalid", core_pc_valid, 0);
        check("rstrun_pcm4", core_pc_start_minus4, 0);
        check("rstrun_cycles", cycles_run_o, 0);
        check("rstrun_busy", busy_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneBase = donePulses;
        sendWord(header(2'd3, 16'd0), 0);
        check("rstrun_nop_busy", busy_o, 0);
        repeat (3) @(negedge clk);
        check("rstrun_no_done", donePulses - doneBase, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
